// File: rtl/ch_copy_engine_if.sv
`default_nettype none
// ============================================================================
// ch_copy_engine_if : channel-buffer FIFO bus between copy engine and channel
// Revision: 1.0
// ============================================================================
interface ch_copy_engine_if #(
   parameter int DATA_WIDTH = 64
);
   logic                  m_src_getn;
   logic [DATA_WIDTH-1:0] m_src;
   logic                  m_src_last;
   logic                  m_src_empty;
   logic                  m_dst_putn;
   logic [DATA_WIDTH-1:0] m_dst;
   logic                  m_dst_last;
   logic                  m_dst_almost_full;
   logic                  m_dst_full;
   logic                  m_endn;

   modport master (
      output m_src_getn,
      input  m_src,
      input  m_src_last,
      input  m_src_empty,
      output m_dst_putn,
      output m_dst,
      output m_dst_last,
      input  m_dst_almost_full,
      input  m_dst_full,
      output m_endn
   );

   modport slave (
      input  m_src_getn,
      output m_src,
      output m_src_last,
      output m_src_empty,
      input  m_dst_putn,
      input  m_dst,
      input  m_dst_last,
      output m_dst_almost_full,
      output m_dst_full,
      input  m_endn
   );
endinterface
`default_nettype wire

// File: rtl/ch_copy_engine.sv
`default_nettype none
// ============================================================================
// ch_copy_engine : copies source FIFO words to destination FIFO, then a trailer
// Revision: 1.0
// ============================================================================
module ch_copy_engine #(
   parameter int DATA_WIDTH = 64,
   parameter int CNT_WIDTH  = 32,
   parameter bit TRAILER_EN = 1'b1
) (
   input  wire logic                 wb_clk_i,
   input  wire logic                 wb_rst_i,
   input  wire logic                 m_reset,
   input  wire logic                 start,
   ch_copy_engine_if.master          m,
   output logic                      busy,
   output logic                      done,
   output logic [CNT_WIDTH-1:0]      wcnt
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_RUN   = 2'd1;
   localparam logic [1:0] c_TRAIL = 2'd2;
   localparam logic [1:0] c_DONE  = 2'd3;

   logic [1:0]            r_state;
   logic                  r_rd_pend;
   logic                  r_last_seen;
   logic                  r_hold_vld;
   logic                  r_hold_last;
   logic [DATA_WIDTH-1:0] r_hold;
   logic                  r_out_vld;
   logic                  r_out_src_last;
   logic                  r_dst_last;
   logic [DATA_WIDTH-1:0] r_dst;
   logic                  r_endn;
   logic [CNT_WIDTH-1:0]  r_wcnt;
   logic [31:0]           r_chk;

   logic                  w_rd;
   logic                  w_ret;
   logic                  w_put;
   logic                  w_out_free;
   logic                  w_trl_load;
   logic [31:0]           w_fold;
   logic [DATA_WIDTH-1:0] w_trailer;

   // The m_src_last term stops a read in the cycle the last word is returned,
   // so the following job's first word is never pulled from the FIFO.
   assign w_rd = !m_reset && (r_state == c_RUN) && !m.m_src_empty
                 && !m.m_dst_almost_full && !r_hold_vld && !r_last_seen
                 && !(r_rd_pend && m.m_src_last);
   assign w_ret      = r_rd_pend;
   assign w_put      = !m_reset && r_out_vld && !m.m_dst_full;
   assign w_out_free = !r_out_vld || w_put;
   assign w_trl_load = (r_state == c_TRAIL) && !r_out_vld && !r_hold_vld;
   assign w_fold     = r_dst[63:32] ^ r_dst[31:0];

   generate
      if (TRAILER_EN) begin : g_trailer_on
         assign w_trailer = DATA_WIDTH'({r_chk, r_wcnt[31:0]});
      end else begin : g_trailer_off
         assign w_trailer = '0;
      end
   endgenerate

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         r_state        <= c_IDLE;
         r_rd_pend      <= 1'b0;
         r_last_seen    <= 1'b0;
         r_hold_vld     <= 1'b0;
         r_hold_last    <= 1'b0;
         r_hold         <= '0;
         r_out_vld      <= 1'b0;
         r_out_src_last <= 1'b0;
         r_dst_last     <= 1'b0;
         r_dst          <= '0;
         r_endn         <= 1'b1;
         r_wcnt         <= '0;
         r_chk          <= '0;
      end else if (m_reset) begin
         r_state        <= c_IDLE;
         r_rd_pend      <= 1'b0;
         r_last_seen    <= 1'b0;
         r_hold_vld     <= 1'b0;
         r_hold_last    <= 1'b0;
         r_hold         <= '0;
         r_out_vld      <= 1'b0;
         r_out_src_last <= 1'b0;
         r_dst_last     <= 1'b0;
         r_dst          <= '0;
         r_endn         <= 1'b1;
         r_wcnt         <= '0;
         r_chk          <= '0;
      end else begin
         r_rd_pend <= w_rd;
         if (w_ret && m.m_src_last) begin
            r_last_seen <= 1'b1;
         end

         // Output register refills from hold first to keep word order.
         if (w_out_free) begin
            if (r_hold_vld) begin
               r_out_vld      <= 1'b1;
               r_dst          <= r_hold;
               r_out_src_last <= r_hold_last;
               r_dst_last     <= 1'b0;
               r_hold_vld     <= w_ret;
               if (w_ret) begin
                  r_hold      <= m.m_src;
                  r_hold_last <= m.m_src_last;
               end
            end else if (w_ret) begin
               r_out_vld      <= 1'b1;
               r_dst          <= m.m_src;
               r_out_src_last <= m.m_src_last;
               r_dst_last     <= 1'b0;
            end else if (w_trl_load) begin
               r_out_vld      <= 1'b1;
               r_dst          <= w_trailer;
               r_out_src_last <= 1'b0;
               r_dst_last     <= 1'b1;
            end else begin
               r_out_vld      <= 1'b0;
            end
         end else if (w_ret) begin
            r_hold_vld  <= 1'b1;
            r_hold      <= m.m_src;
            r_hold_last <= m.m_src_last;
         end

         if (w_put && !r_dst_last) begin
            r_wcnt <= r_wcnt + 1'b1;
            r_chk  <= r_chk ^ w_fold;
         end

         case (r_state)
            c_IDLE, c_DONE: begin
               if (start) begin
                  r_state     <= c_RUN;
                  r_wcnt      <= '0;
                  r_chk       <= '0;
                  r_last_seen <= 1'b0;
                  r_endn      <= 1'b1;
               end
            end
            c_RUN: begin
               if (w_put && r_out_src_last) begin
                  r_state <= c_TRAIL;
               end
            end
            c_TRAIL: begin
               if (w_put && r_dst_last) begin
                  r_state <= c_DONE;
                  r_endn  <= 1'b0;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign m.m_src_getn = !w_rd;
   assign m.m_dst_putn = !w_put;
   assign m.m_dst      = r_dst;
   assign m.m_dst_last = r_dst_last;
   assign m.m_endn     = r_endn;
   assign busy         = (r_state == c_RUN) || (r_state == c_TRAIL);
   assign done         = (r_state == c_DONE);
   assign wcnt         = r_wcnt;

endmodule
`default_nettype wire

// File: tb/tb_ch_copy_engine.sv
`default_nettype none
// ============================================================================
// tb_ch_copy_engine : job table + scoreboard bench for ch_copy_engine
// Revision: 1.0
// ============================================================================
module tb_ch_copy_engine;

   typedef struct {
      string       name;
      int          nw;
      int          pat;
      int          full_at;
      bit          gaps;
      bit          extra;
      logic [31:0] exp_wcnt;
      logic [31:0] exp_chk;
   } job_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        m_reset = 1'b0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] wcnt;

   int          n_checks = 0;
   int          n_fail = 0;
   int          sink_cnt = 0;
   int          empty_viol = 0;
   bit          abort_mode = 1'b0;
   bit          pop = 1'b0;
   logic [64:0] src_q[$];
   logic [64:0] sb_q[$];
   job_t        tbl[4];

   localparam logic [64:0] c_EXTRA = {1'b0, 64'hFEED_FACE_0BAD_CAFE};

   ch_copy_engine_if #(.DATA_WIDTH(64)) m ();

   ch_copy_engine #(
      .DATA_WIDTH (64),
      .CNT_WIDTH  (32),
      .TRAILER_EN (1'b1)
   ) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst_n),
      .m_reset  (m_reset),
      .start    (start),
      .m        (m),
      .busy     (busy),
      .done     (done),
      .wcnt     (wcnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] word(input int pat, input int i);
      logic [31:0] lo;
      lo = 32'h5A5A_0000;
      case (pat)
         0: case (i)
               1:       word = 64'hA0A0_A0A0_A0A0_A0A0;
               2:       word = 64'hB1B1_B1B1_B1B1_B1B1;
               3:       word = 64'hC2C2_C2C2_C2C2_C2C2;
               default: word = 64'hD3D3_D3D3_D3D3_D3D3;
            endcase
         1: word = 64'hDEAD_BEEF_0000_0001;
         default: word = {32'(i) ^ lo, lo};
      endcase
   endfunction

   // Source FIFO model: read strobe sampled mid-cycle, data presented after the edge.
   always @(negedge clk) begin
      pop = !m.m_src_getn;
      if (!m.m_src_getn && m.m_src_empty) empty_viol++;
   end

   always @(posedge clk) begin
      #1;
      if (pop && src_q.size() > 0) {m.m_src_last, m.m_src} = src_q.pop_front();
      #1;
      m.m_src_empty = (src_q.size() == 0);
   end

   // Destination sink: every write compared against the scoreboard.
   always @(negedge clk) begin
      logic [64:0] exp;
      if (!m.m_dst_putn) begin
         sink_cnt++;
         chk("putn_while_full", {64'd0, m.m_dst_full}, 65'd0);
         if (!abort_mode) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_write", {m.m_dst_last, m.m_dst}, 65'h1_FFFF_FFFF_FFFF_FFFF);
            end else begin
               exp = sb_q.pop_front();
               chk("dst_word", {m.m_dst_last, m.m_dst}, exp);
            end
         end
      end
   end

   task automatic check_reset(input string tag);
      chk({tag, "_getn"},  {64'd0, m.m_src_getn}, 65'd1);
      chk({tag, "_putn"},  {64'd0, m.m_dst_putn}, 65'd1);
      chk({tag, "_dst"},   {1'b0, m.m_dst},       65'd0);
      chk({tag, "_last"},  {64'd0, m.m_dst_last}, 65'd0);
      chk({tag, "_endn"},  {64'd0, m.m_endn},     65'd1);
      chk({tag, "_busy"},  {64'd0, busy},         65'd0);
      chk({tag, "_done"},  {64'd0, done},         65'd0);
      chk({tag, "_wcnt"},  {33'd0, wcnt},         65'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_job(input job_t j);
      sink_cnt   = 0;
      empty_viol = 0;
      abort_mode = 1'b0;
      for (int i = 1; i <= j.nw; i++) begin
         sb_q.push_back({1'b0, word(j.pat, i)});
         if (!j.gaps || i == 1) src_q.push_back({(i == j.nw), word(j.pat, i)});
      end
      sb_q.push_back({1'b1, j.exp_chk, j.exp_wcnt});
      if (j.extra && !j.gaps) src_q.push_back(c_EXTRA);
      pulse_start();
      chk({j.name, "_busy"}, {64'd0, busy}, 65'd1);
      fork
         begin
            if (j.gaps) begin
               for (int i = 2; i <= j.nw; i++) begin
                  repeat (3) tick();
                  src_q.push_back({(i == j.nw), word(j.pat, i)});
               end
               if (j.extra) src_q.push_back(c_EXTRA);
            end
         end
         begin
            if (j.full_at > 0) begin
               for (int c = 0; c < 400 && sink_cnt < j.full_at; c++) tick();
               m.m_dst_full = 1'b1;
               m.m_dst_almost_full = 1'b1;
               repeat (5) tick();
               m.m_dst_full = 1'b0;
               m.m_dst_almost_full = 1'b0;
            end
         end
      join
      for (int c = 0; c < 600 && done !== 1'b1; c++) tick();
      chk({j.name, "_done"},   {64'd0, done},          65'd1);
      chk({j.name, "_endn"},   {64'd0, m.m_endn},      65'd0);
      chk({j.name, "_idle"},   {64'd0, busy},          65'd0);
      chk({j.name, "_wcnt"},   {33'd0, wcnt},          {33'd0, j.exp_wcnt});
      chk({j.name, "_writes"}, 65'(sink_cnt),          65'(j.nw + 1));
      chk({j.name, "_sb_left"}, 65'(sb_q.size()),      65'd0);
      chk({j.name, "_get_empty"}, 65'(empty_viol),     65'd0);
      if (j.extra) begin
         repeat (4) tick();
         chk({j.name, "_fifo_left"}, 65'(src_q.size()), 65'd1);
         if (src_q.size() > 0) chk({j.name, "_queued"}, src_q[0], c_EXTRA);
      end
      sb_q.delete();
   endtask

   initial begin
      m.m_src             = '0;
      m.m_src_last        = 1'b0;
      m.m_src_empty       = 1'b1;
      m.m_dst_almost_full = 1'b0;
      m.m_dst_full        = 1'b0;

      //         name            nw pat full gaps extra wcnt    chk
      tbl[0] = '{"T1_burst4",     4, 0,  0,  0,   0,   32'd4,  32'h0000_0000};
      tbl[1] = '{"T2_single",     1, 1,  0,  0,   0,   32'd1,  32'hDEAD_BEEE};
      tbl[2] = '{"T3_full_stall",16, 2,  6,  0,   0,   32'd16, 32'h0000_0010};
      tbl[3] = '{"T4_gaps",       6, 2,  0,  1,   1,   32'd6,  32'h0000_0007};

      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst_n = 1'b1;
      tick();

      for (int t = 0; t < 4; t++) begin
         src_q.delete();
         run_job(tbl[t]);
         tick();
      end

      // T5: synchronous job clear after three written words
      src_q.delete();
      for (int i = 1; i <= 10; i++) src_q.push_back({(i == 10), word(2, i)});
      abort_mode = 1'b1;
      pulse_start();
      for (int c = 0; c < 200 && wcnt != 32'd3; c++) tick();
      chk("T5_wcnt_before_clear", {33'd0, wcnt}, 65'd3);
      m_reset = 1'b1;
      tick();
      m_reset = 1'b0;
      check_reset("T5");
      src_q.delete();
      tick();
      run_job(tbl[1]);
      tick();

      // T6: asynchronous reset asserted between clock edges
      src_q.delete();
      for (int i = 1; i <= 20; i++) src_q.push_back({(i == 20), word(2, i)});
      abort_mode = 1'b1;
      pulse_start();
      for (int c = 0; c < 200 && wcnt < 32'd2; c++) tick();
      chk("T6_running", {64'd0, busy}, 65'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("T6");
      tick();
      rst_n = 1'b1;
      src_q.delete();
      tick();
      run_job(tbl[0]);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
